// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 scheduler: sequencer states, S-memory grant codes
// and the mapping between them.
package arc4_pkg;

    localparam int S_DEPTH   = 256;
    localparam int KEY_W_DEF = 24;

    typedef enum logic [2:0] {
        IDLE,
        ST_INIT,
        WT_INIT,
        ST_KSA,
        WT_KSA,
        ST_PRGA,
        WT_PRGA
    } sched_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_INIT = 2'd1,
        GRANT_KSA  = 2'd2,
        GRANT_PRGA = 2'd3
    } grant_t;

    function automatic grant_t grant_of(input sched_state_t s);
        case (s)
            ST_INIT, WT_INIT: return GRANT_INIT;
            ST_KSA,  WT_KSA:  return GRANT_KSA;
            ST_PRGA, WT_PRGA: return GRANT_PRGA;
            default:          return GRANT_NONE;
        endcase
    endfunction

    // Start state for engine index 0=init, 1=ksa, 2=prga.
    function automatic sched_state_t st_state(input int idx);
        case (idx)
            0:       return ST_INIT;
            1:       return ST_KSA;
            default: return ST_PRGA;
        endcase
    endfunction

endpackage

// File: rtl/s_mem_mux.sv
// Combinational 3:1 selector of the S-memory write port; only the granted
// engine reaches the memory, everything else is masked to zero.
module s_mem_mux
    import arc4_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  grant_t                  grant,
    input  logic [2:0][ADDR_W-1:0]  eng_addr,
    input  logic [2:0][DATA_W-1:0]  eng_wrdata,
    input  logic [2:0]              eng_wren,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wrdata,
    output logic                    s_wren
);

    logic [2:0] sel;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sel
            assign sel[gi] = (grant == 2'(gi + 1));
        end
    endgenerate

    // AND-OR mux: sel is one-hot or all zero, so the OR never merges engines.
    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sel[i]) begin
                s_addr   = s_addr   | eng_addr[i];
                s_wrdata = s_wrdata | eng_wrdata[i];
                s_wren   = s_wren   | eng_wren[i];
            end
        end
    end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 sequencer: runs init -> ksa -> prga once per accepted start and
// grants the single-port S memory to whichever engine is currently active.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int KEY_W  = KEY_W_DEF,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    output logic [KEY_W-1:0]  key_o,
    output logic              init_en,
    input  logic              init_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic              init_wren,
    output logic              ksa_en,
    input  logic              ksa_rdy,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic              ksa_wren,
    output logic              prga_en,
    input  logic              prga_rdy,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren,
    input  logic [DATA_W-1:0] s_rddata,
    output logic [DATA_W-1:0] s_rddata_o
);

    sched_state_t     state_reg, state_next;
    logic             busy_seen_reg, busy_seen_next;
    logic [2:0]       eng_rdy;
    logic [2:0]       eng_en_reg, eng_en_next;
    logic [KEY_W-1:0] key_reg;

    assign eng_rdy = {prga_rdy, ksa_rdy, init_rdy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            busy_seen_reg <= 1'b0;
            key_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            busy_seen_reg <= busy_seen_next;
            if (state_reg == IDLE && en)
                key_reg <= key;
        end
    end

    // WT_x only exits after the engine has been seen busy, so an engine that
    // drops rdy a cycle after accepting its start is not mistaken for done.
    always_comb begin
        state_next     = state_reg;
        busy_seen_next = 1'b0;
        case (state_reg)
            IDLE:    if (en) state_next = ST_INIT;
            ST_INIT: if (eng_en_reg[0]) state_next = WT_INIT;
            WT_INIT: begin
                busy_seen_next = busy_seen_reg | ~init_rdy;
                if (init_rdy && busy_seen_reg) state_next = ST_KSA;
            end
            ST_KSA:  if (eng_en_reg[1]) state_next = WT_KSA;
            WT_KSA: begin
                busy_seen_next = busy_seen_reg | ~ksa_rdy;
                if (ksa_rdy && busy_seen_reg) state_next = ST_PRGA;
            end
            ST_PRGA: if (eng_en_reg[2]) state_next = WT_PRGA;
            WT_PRGA: begin
                busy_seen_next = busy_seen_reg | ~prga_rdy;
                if (prga_rdy && busy_seen_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Start pulses are registered: raised on the edge that lands in (or stays
    // in) ST_x with the engine ready, and the following edge leaves ST_x.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_start
            assign eng_en_next[gi] = (state_next == st_state(gi)) && eng_rdy[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    eng_en_reg[gi] <= 1'b0;
                else
                    eng_en_reg[gi] <= eng_en_next[gi];
            end
        end
    endgenerate

    assign rdy        = (state_reg == IDLE);
    assign key_o      = key_reg;
    assign init_en    = eng_en_reg[0];
    assign ksa_en     = eng_en_reg[1];
    assign prga_en    = eng_en_reg[2];
    assign s_rddata_o = s_rddata;

    s_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_s_mem_mux (
        .grant      (grant_of(state_reg)),
        .eng_addr   ({prga_addr, ksa_addr, init_addr}),
        .eng_wrdata ({prga_wrdata, ksa_wrdata, init_wrdata}),
        .eng_wren   ({prga_wren, ksa_wren, init_wren}),
        .s_addr     (s_addr),
        .s_wrdata   (s_wrdata),
        .s_wren     (s_wren)
    );

endmodule
